// File: rtl/ac_op_sequencer.sv
// Sequencer for the AC arithmetic unit: accepts one AC/E op per handshake, fetches
// the DR operand when the op needs one, drives one unit select in EXEC and owns AC, E and DR.
module ac_op_sequencer #(
    parameter int unsigned TIMEOUT   = 200,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_code,
    output logic        dr_req,
    input  logic        dr_ack,
    input  logic [15:0] dr_in,
    input  logic [15:0] acdata,
    input  logic        cout,
    output logic        sel_and,
    output logic        sel_add,
    output logic        sel_inpt,
    output logic        sel_dr,
    output logic        sel_com,
    output logic        sel_shl,
    output logic        sel_shr,
    output logic [15:0] dr,
    output logic [15:0] ac,
    output logic        e,
    output logic        done,
    output logic        skip,
    output logic        err
);

    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PREP,
        S_EXEC,
        S_DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_AND = 4'h1,
        OP_ADD = 4'h2,
        OP_LDA = 4'h3,
        OP_CLA = 4'h4,
        OP_CLE = 4'h5,
        OP_CMA = 4'h6,
        OP_CME = 4'h7,
        OP_CIR = 4'h8,
        OP_CIL = 4'h9,
        OP_INC = 4'hA,
        OP_INP = 4'hB,
        OP_SZA = 4'hC,
        OP_SNA = 4'hD,
        OP_SPA = 4'hE,
        OP_SZE = 4'hF
    } op_t;

    state_t               state;
    state_t               next_state;
    op_t                  op_q;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 accept;
    logic                 fetch_expired;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and unit selects; selects decode only the latched op and only in EXEC
    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        fetch_expired = 1'b0;
        sel_and       = 1'b0;
        sel_add       = 1'b0;
        sel_inpt      = 1'b0;
        sel_dr        = 1'b0;
        sel_com       = 1'b0;
        sel_shl       = 1'b0;
        sel_shr       = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_valid) begin
                    accept = 1'b1;
                    case (op_t'(op_code))
                        OP_AND, OP_ADD, OP_LDA: next_state = S_FETCH;
                        OP_INC:                 next_state = S_PREP;
                        default:                next_state = S_EXEC;
                    endcase
                end
            end
            S_FETCH: begin
                if (dr_ack) begin
                    next_state = S_EXEC;
                end else if (wait_cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
                    fetch_expired = 1'b1;
                    next_state    = S_DONE;
                end
            end
            S_PREP: next_state = S_EXEC;
            S_EXEC: begin
                next_state = S_DONE;
                case (op_q)
                    OP_AND:         sel_and  = 1'b1;
                    OP_ADD, OP_INC: sel_add  = 1'b1;
                    OP_LDA:         sel_dr   = 1'b1;
                    OP_CMA:         sel_com  = 1'b1;
                    OP_INP:         sel_inpt = 1'b1;
                    OP_CIR:         sel_shr  = 1'b1;
                    OP_CIL:         sel_shl  = 1'b1;
                    default:        ;
                endcase
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Handshake and status flags follow the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_ready <= 1'b1;
            dr_req   <= 1'b0;
            done     <= 1'b0;
        end else begin
            op_ready <= (next_state == S_IDLE);
            dr_req   <= (next_state == S_FETCH);
            done     <= (next_state == S_DONE);
        end
    end

    // Op latch and fetch-wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_NOP;
            wait_cnt <= '0;
        end else if (accept) begin
            op_q     <= op_t'(op_code);
            wait_cnt <= '0;
        end else if (state == S_FETCH) begin
            wait_cnt <= wait_cnt + TIMEOUT_W'(1);
        end
    end

    // DR load: memory operand in FETCH, constant one for INC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dr <= '0;
        end else if (state == S_FETCH && dr_ack) begin
            dr <= dr_in;
        end else if (state == S_PREP) begin
            dr <= DATA_W'(1);
        end
    end

    // AC/E writeback and skip/err flags, which live exactly one cycle alongside done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac   <= '0;
            e    <= 1'b0;
            skip <= 1'b0;
            err  <= 1'b0;
        end else begin
            skip <= 1'b0;
            err  <= fetch_expired;
            if (state == S_EXEC) begin
                case (op_q)
                    OP_AND, OP_LDA, OP_CMA: ac <= acdata;
                    OP_ADD, OP_INC: begin
                        ac <= acdata;
                        e  <= cout;
                    end
                    OP_INP: ac <= {8'h00, acdata[7:0]};
                    OP_CIR: begin
                        ac <= acdata;
                        e  <= ac[0];
                    end
                    OP_CIL: begin
                        ac <= acdata;
                        e  <= ac[DATA_W-1];
                    end
                    OP_CLA: ac <= '0;
                    OP_CLE: e <= 1'b0;
                    OP_CME: e <= ~e;
                    OP_SZA: skip <= (ac == '0);
                    OP_SNA: skip <= ac[DATA_W-1];
                    OP_SPA: skip <= ~ac[DATA_W-1] && (ac != '0);
                    OP_SZE: skip <= ~e;
                    default: ;
                endcase
            end
        end
    end

endmodule
